// File: rtl/draw_sequencer_pkg.sv
// Shared types and screen geometry for the clear+draw pixel sequencer.
// Screen is 160x120; coordinates outside it are clipped before reaching the VGA adapter.
package draw_sequencer_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;
   localparam int COUNT_W  = 15;

   localparam logic [X_W-1:0]     X_LAST    = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0]     Y_LAST    = Y_W'(SCREEN_H - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x <= X_LAST) && (y <= Y_LAST);
   endfunction

endpackage

// File: rtl/vga_clip.sv
// Bounds check and single register stage for the pixel path; off-screen plots
// are dropped and the last forwarded pixel's coordinates/colour are held.
module vga_clip
   import draw_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [X_W-1:0]      i_x,
   input  logic [Y_W-1:0]      i_y,
   input  logic [COLOUR_W-1:0] i_colour,
   input  logic                i_plot,
   output logic                o_fwd,
   output logic [X_W-1:0]      o_x,
   output logic [Y_W-1:0]      o_y,
   output logic [COLOUR_W-1:0] o_colour,
   output logic                o_plot
);

   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [COLOUR_W-1:0] r_colour;
   logic                r_plot;
   logic                w_fwd;

   assign w_fwd = i_plot && on_screen(i_x, i_y);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
      end else begin
         r_plot <= w_fwd;
         // Holding coordinates when nothing is forwarded keeps outputs quiet while idle.
         if (w_fwd) begin
            r_x      <= i_x;
            r_y      <= i_y;
            r_colour <= i_colour;
         end
      end
   end

   assign o_fwd    = w_fwd;
   assign o_x      = r_x;
   assign o_y      = r_y;
   assign o_colour = r_colour;
   assign o_plot   = r_plot;

endmodule

// File: rtl/draw_sequencer.sv
// Runs one clear pass (fill engine) then one draw pass (shape engine) per start request,
// muxing the owning engine's pixels to the VGA adapter and counting forwarded pixels.
module draw_sequencer
   import draw_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                done,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                fill_start,
   output logic [COLOUR_W-1:0] fill_colour,
   input  logic                fill_done,
   input  logic [X_W-1:0]      fill_x,
   input  logic [Y_W-1:0]      fill_y,
   input  logic [COLOUR_W-1:0] fill_vcolour,
   input  logic                fill_plot,
   output logic                shape_start,
   input  logic                shape_done,
   input  logic [X_W-1:0]      shape_x,
   input  logic [Y_W-1:0]      shape_y,
   input  logic [COLOUR_W-1:0] shape_colour,
   input  logic                shape_plot,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic [COUNT_W-1:0]  plot_count,
   output logic [1:0]          dbg_state
);

   state_t               r_state;
   state_t               w_next;
   logic [COUNT_W-1:0]   r_count;
   logic [X_W-1:0]       w_sel_x;
   logic [Y_W-1:0]       w_sel_y;
   logic [COLOUR_W-1:0]  w_sel_colour;
   logic                 w_sel_plot;
   logic                 w_fwd;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Engine handshakes are Moore outputs of the state, so the two starts can never overlap
   // and only the engine that owns the current state reaches the pixel path.
   always_comb begin
      w_next       = r_state;
      fill_start   = 1'b0;
      fill_colour  = '0;
      shape_start  = 1'b0;
      done         = 1'b0;
      w_sel_x      = '0;
      w_sel_y      = '0;
      w_sel_colour = '0;
      w_sel_plot   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = CLEAR;
         end
         CLEAR: begin
            fill_start   = 1'b1;
            fill_colour  = clear_colour;
            w_sel_x      = fill_x;
            w_sel_y      = fill_y;
            w_sel_colour = fill_vcolour;
            w_sel_plot   = fill_plot;
            if (fill_done) w_next = DRAW;
         end
         DRAW: begin
            shape_start  = 1'b1;
            w_sel_x      = shape_x;
            w_sel_y      = shape_y;
            w_sel_colour = shape_colour;
            w_sel_plot   = shape_plot;
            if (shape_done) w_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (!start) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   vga_clip u_clip (
      .clk      (clk),
      .rst      (rst),
      .i_x      (w_sel_x),
      .i_y      (w_sel_y),
      .i_colour (w_sel_colour),
      .i_plot   (w_sel_plot),
      .o_fwd    (w_fwd),
      .o_x      (vga_x),
      .o_y      (vga_y),
      .o_colour (vga_colour),
      .o_plot   (vga_plot)
   );

   // Count moves on the same edge as vga_plot so the two always agree.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (r_state == IDLE && start) begin
         r_count <= '0;
      end else if (w_fwd && r_count != COUNT_MAX) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign plot_count = r_count;
   assign dbg_state  = r_state;

endmodule
